// File: rtl/game_round_controller.sv
// Round sequencer for a two-tank arena game: attract screen, 3-2-1 countdown,
// play, post-hit freeze and game over, all paced by VGA frame ticks.
module game_round_controller #(
  parameter int         WIN_SCORE    = 5,
  parameter int         COUNT_FRAMES = 60,
  parameter int         HIT_FRAMES   = 90,
  parameter logic [7:0] START_KEY    = 8'h28
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       vs,
  input  logic [7:0] keycode,
  input  logic       hit1,
  input  logic       hit2,
  output logic [2:0] state,
  output logic       tanks_enable,
  output logic       round_reset,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] countdown,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    ST_ATTRACT   = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_HIT       = 3'd3,
    ST_GAMEOVER  = 3'd4
  } state_t;

  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [7:0] COUNT_LAST = 8'(COUNT_FRAMES - 1);
  localparam logic [7:0] HIT_LAST   = 8'(HIT_FRAMES - 1);

  state_t     state_reg, state_next;
  logic       vs_prev_reg;
  logic [7:0] key_prev_reg;
  logic [7:0] frame_cnt_reg, frame_cnt_next;
  logic       te_reg, te_next;
  logic       rr_reg, rr_next;
  logic [3:0] s1_reg, s1_next;
  logic [3:0] s2_reg, s2_next;
  logic [1:0] cd_reg, cd_next;
  logic [1:0] win_reg, win_next;

  logic frame_tick;
  logic start_press;

  assign frame_tick  = vs & ~vs_prev_reg;
  assign start_press = (keycode == START_KEY) && (key_prev_reg != START_KEY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_ATTRACT;
      vs_prev_reg   <= 1'b0;
      key_prev_reg  <= 8'h00;
      frame_cnt_reg <= 8'h00;
      te_reg        <= 1'b0;
      rr_reg        <= 1'b0;
      s1_reg        <= 4'd0;
      s2_reg        <= 4'd0;
      cd_reg        <= 2'd0;
      win_reg       <= 2'b00;
    end else begin
      state_reg     <= state_next;
      vs_prev_reg   <= vs;
      key_prev_reg  <= keycode;
      frame_cnt_reg <= frame_cnt_next;
      te_reg        <= te_next;
      rr_reg        <= rr_next;
      s1_reg        <= s1_next;
      s2_reg        <= s2_next;
      cd_reg        <= cd_next;
      win_reg       <= win_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    frame_cnt_next = frame_tick ? frame_cnt_reg + 8'd1 : frame_cnt_reg;
    te_next        = 1'b0;
    rr_next        = 1'b0;
    s1_next        = s1_reg;
    s2_next        = s2_reg;
    cd_next        = cd_reg;
    win_next       = win_reg;

    case (state_reg)
      ST_ATTRACT, ST_GAMEOVER: begin
        if (start_press) begin
          s1_next    = 4'd0;
          s2_next    = 4'd0;
          win_next   = 2'b00;
          cd_next    = 2'd3;
          rr_next    = 1'b1;
          state_next = ST_COUNTDOWN;
        end
      end
      ST_COUNTDOWN: begin
        if (frame_tick && frame_cnt_reg == COUNT_LAST) begin
          frame_cnt_next = 8'h00;
          if (cd_reg == 2'd1) begin
            cd_next    = 2'd0;
            state_next = ST_PLAY;
          end else begin
            cd_next = cd_reg - 2'd1;
          end
        end
      end
      ST_PLAY: begin
        if (hit1 || hit2) begin
          // Each tank's hit scores for the opponent; both may land together.
          if (hit2 && s1_reg < WIN) s1_next = s1_reg + 4'd1;
          if (hit1 && s2_reg < WIN) s2_next = s2_reg + 4'd1;
          state_next = ST_HIT;
        end else begin
          te_next = 1'b1;
        end
      end
      ST_HIT: begin
        if (frame_tick && frame_cnt_reg == HIT_LAST) begin
          if (s1_reg == WIN || s2_reg == WIN) begin
            win_next   = {s2_reg == WIN, s1_reg == WIN};
            state_next = ST_GAMEOVER;
          end else begin
            cd_next    = 2'd3;
            rr_next    = 1'b1;
            state_next = ST_COUNTDOWN;
          end
        end
      end
      default: state_next = ST_ATTRACT;
    endcase

    // Every phase starts its frame count from zero.
    if (state_next != state_reg) frame_cnt_next = 8'h00;
  end

  assign state        = state_reg;
  assign tanks_enable = te_reg;
  assign round_reset  = rr_reg;
  assign score1       = s1_reg;
  assign score2       = s2_reg;
  assign countdown    = cd_reg;
  assign winner       = win_reg;

endmodule

// File: tb/tb_game_round_controller.sv
// Randomised and directed stimulus for game_round_controller, scored per cycle
// against a tick-counting reference model through an expectation queue.
module tb_game_round_controller;
  localparam int         WIN   = 5;
  localparam int         CF    = 2;
  localparam int         HF    = 3;
  localparam logic [7:0] START = 8'h28;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       vs;
  logic [7:0] keycode;
  logic       hit1, hit2;
  logic [2:0] state;
  logic       tanks_enable, round_reset;
  logic [3:0] score1, score2;
  logic [1:0] countdown, winner;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [2:0] st;
    logic       te;
    logic       rr;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] cd;
    logic [1:0] win;
  } snap_t;

  snap_t exp_q[$];
  snap_t mon_exp, mon_act;

  always #10 clk = ~clk;

  game_round_controller #(
    .WIN_SCORE(WIN), .COUNT_FRAMES(CF), .HIT_FRAMES(HF), .START_KEY(START)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vs(vs), .keycode(keycode),
    .hit1(hit1), .hit2(hit2), .state(state), .tanks_enable(tanks_enable),
    .round_reset(round_reset), .score1(score1), .score2(score2),
    .countdown(countdown), .winner(winner)
  );

  // Reference model: phases tracked as ticks elapsed since the phase began.
  int       m_state, m_s1, m_s2, m_cd, m_win, m_ticks;
  bit       m_te, m_rr, m_pvs;
  bit [7:0] m_pkey;

  function automatic snap_t m_snap();
    snap_t s;
    s.st  = 3'(m_state);
    s.te  = m_te;
    s.rr  = m_rr;
    s.s1  = 4'(m_s1);
    s.s2  = 4'(m_s2);
    s.cd  = 2'(m_cd);
    s.win = 2'(m_win);
    return s;
  endfunction

  task automatic m_reset();
    m_state = 0; m_s1 = 0; m_s2 = 0; m_cd = 0; m_win = 0; m_ticks = 0;
    m_te = 0; m_rr = 0; m_pvs = 0; m_pkey = 8'h00;
  endtask

  task automatic m_new_round();
    m_state = 1; m_ticks = 0; m_cd = 3; m_rr = 1;
  endtask

  task automatic m_step(input logic v, input logic [7:0] k, input logic h1, input logic h2);
    bit tick, sp;
    tick   = (v === 1'b1) && !m_pvs;
    sp     = (k == START) && (m_pkey != START);
    m_pvs  = (v === 1'b1);
    m_pkey = k;
    m_rr   = 0;
    m_te   = 0;
    case (m_state)
      0, 4: if (sp) begin
        m_s1 = 0; m_s2 = 0; m_win = 0;
        m_new_round();
      end
      1: if (tick) begin
        m_ticks++;
        if (m_ticks == 3 * CF) begin m_state = 2; m_cd = 0; end
        else m_cd = 3 - m_ticks / CF;
      end
      2: if (h1 || h2) begin
        m_s1 = (m_s1 + int'(h2) > WIN) ? WIN : m_s1 + int'(h2);
        m_s2 = (m_s2 + int'(h1) > WIN) ? WIN : m_s2 + int'(h1);
        m_state = 3; m_ticks = 0;
      end else begin
        m_te = 1;
      end
      3: if (tick) begin
        m_ticks++;
        if (m_ticks == HF) begin
          if (m_s1 == WIN || m_s2 == WIN) begin
            m_state = 4;
            m_win = (m_s1 == WIN ? 1 : 0) + (m_s2 == WIN ? 2 : 0);
          end else begin
            m_new_round();
          end
        end
      end
      default: m_state = 0;
    endcase
  endtask

  // Exactly one expectation is pending between a clock edge and the next falling edge.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_reset();
      exp_q.delete();
      exp_q.push_back(m_snap());
    end else begin
      m_step(vs, keycode, hit1, hit2);
      exp_q.push_back(m_snap());
    end
  end

  // Monitor: per-cycle compare on the falling edge; immediate check on async reset.
  always @(negedge clk or negedge reset_n) begin
    if (clk === 1'b1) begin
      #1;
      vectors++;
      if ({state, tanks_enable, round_reset, score1, score2, countdown, winner} !== '0) begin
        miscompares++;
        $display("FAIL async_reset @%0t: got st=%0d te=%0b rr=%0b s1=%0d s2=%0d cd=%0d win=%b, want all zero",
                 $time, state, tanks_enable, round_reset, score1, score2, countdown, winner);
      end
    end else if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {state, tanks_enable, round_reset, score1, score2, countdown, winner};
      vectors++;
      if (mon_act !== mon_exp) begin
        miscompares++;
        $display("FAIL outputs @%0t: got st=%0d te=%0b rr=%0b s1=%0d s2=%0d cd=%0d win=%b, want st=%0d te=%0b rr=%0b s1=%0d s2=%0d cd=%0d win=%b",
                 $time, mon_act.st, mon_act.te, mon_act.rr, mon_act.s1, mon_act.s2, mon_act.cd, mon_act.win,
                 mon_exp.st, mon_exp.te, mon_exp.rr, mon_exp.s1, mon_exp.s2, mon_exp.cd, mon_exp.win);
      end
    end
  end

  bit rand_vs = 0;
  int phase = 0;

  task automatic tick_cycle(input logic [7:0] k, input logic h1, input logic h2);
    @(posedge clk);
    #3;
    keycode = k; hit1 = h1; hit2 = h2;
    if (rand_vs) vs = 1'($urandom_range(0, 1));
    else begin
      phase++;
      vs = (phase % 4) < 2;
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #5 reset_n = 1'b0;
    repeat (n) @(posedge clk);
    #3 reset_n = 1'b1;
  endtask

  // until_eq=1: run until state==st; until_eq=0: run while state==st.
  task automatic run_state(input logic [2:0] st, input bit until_eq, input logic h1, input logic h2);
    int n;
    n = 0;
    while (until_eq ? (state !== st) : (state === st)) begin
      if (n == 500) begin
        $display("FAIL wait_state: state=%0d stuck, target %0d until_eq=%0b", state, st, until_eq);
        $fatal(1, "wait budget exhausted");
      end
      tick_cycle(8'h00, h1, h2);
      n++;
    end
  endtask

  task automatic play_round(input logic h1, input logic h2);
    run_state(3'd2, 1'b1, 1'b0, 1'b0);
    tick_cycle(8'h00, 1'b0, 1'b0);
    tick_cycle(8'h00, h1, h2);
    tick_cycle(8'h00, 1'b0, 1'b0);
    run_state(3'd3, 1'b0, 1'b1, 1'b1);
  endtask

  logic [7:0] rkey;
  logic       rh1, rh2;

  initial begin
    vs = 1'b0; keycode = 8'h00; hit1 = 1'b0; hit2 = 1'b0;
    do_reset(2);
    repeat (5) tick_cycle(8'h00, 1'b0, 1'b0);
    // Start key held: one start only.
    repeat (10) tick_cycle(START, 1'b0, 1'b0);
    tick_cycle(8'h00, 1'b0, 1'b0);
    // Second press during countdown must be ignored.
    repeat (2) tick_cycle(START, 1'b0, 1'b0);
    play_round(1'b0, 1'b1);
    run_state(3'd1, 1'b1, 1'b1, 1'b0);
    repeat (4) tick_cycle(8'h00, 1'b1, 1'b0);
    play_round(1'b1, 1'b0);
    repeat (4) play_round(1'b1, 1'b1);
    repeat (6) tick_cycle(8'h00, 1'b1, 1'b1);
    // Restart from game over.
    tick_cycle(START, 1'b0, 1'b0);
    tick_cycle(8'h00, 1'b0, 1'b0);
    repeat (3) play_round(1'b0, 1'b1);
    run_state(3'd2, 1'b1, 1'b0, 1'b0);
    tick_cycle(8'h00, 1'b0, 1'b0);
    do_reset(2);
    repeat (4) tick_cycle(8'h00, 1'b1, 1'b1);

    rand_vs = 1;
    rkey = 8'h00;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0, 1:    rkey = 8'h00;
          2:       rkey = START;
          default: rkey = 8'h04;
        endcase
      end
      rh1 = ($urandom_range(0, 7) == 0);
      rh2 = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 799) == 0) do_reset(1);
      else tick_cycle(rkey, rh1, rh2);
    end

    repeat (3) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
